csel_subtractor_seq: RTL and testbench



---
 rtl/csel_subtractor_seq.sv | 130 +++++++++++++
 tb/tb_csel_subtractor_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/csel_subtractor_seq.sv
// csel_subtractor_seq: nibble-serial carry-select subtractor, diff = a - b - borrow_in.
// Optional macro CSEL_SUB_SAT_EN saturates diff on signed overflow.
`default_nettype none

module csel_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              bor_q, bor_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [3:0] a_nib, b_nib;
  logic [4:0] d0, d1, sel;
  logic       ovf_calc;

  assign a_nib = a_q[4*idx_q +: 4];
  assign b_nib = b_q[4*idx_q +: 4];

  // Both borrow-in candidates are formed every cycle; the registered borrow picks one.
  assign d0  = {1'b0, a_nib} - {1'b0, b_nib};
  assign d1  = {1'b0, a_nib} - {1'b0, b_nib} - 5'd1;
  assign sel = bor_q ? d1 : d0;

  // Only meaningful on the last nibble, where sel[3] is the result MSB.
  assign ovf_calc = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sel[3] ^ a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          bor_d   = borrow_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[4*idx_q +: 4] = sel[3:0];
        bor_d = sel[4];
        idx_d = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          bout_d  = sel[4];
          ovf_d   = ovf_calc;
          state_d = DONE;
`ifdef CSEL_SUB_SAT_EN
          if (ovf_calc) begin
            diff_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
          end
`else
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_csel_subtractor_seq.sv
// tb_csel_subtractor_seq: vector table, hand sequences and random ops vs. an arithmetic model.
`default_nettype none

module tb_csel_subtractor_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

`ifdef CSEL_SUB_SAT_EN
  localparam logic [W-1:0] OV1 = 16'h8000;
  localparam logic [W-1:0] OV2 = 16'h7FFF;
`else
  localparam logic [W-1:0] OV1 = 16'h7FFF;
  localparam logic [W-1:0] OV2 = 16'h8000;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  always #5 clk = ~clk;

  csel_subtractor_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the whole word.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    int unsigned ai, bi, bb;
    ai  = ma;
    bi  = mb;
    bb  = mbin;
    mbo = (ai < bi + bb);
    md  = W'(ai - bi - bb);
    mov = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
`ifdef CSEL_SUB_SAT_EN
    if (mov) md = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  endfunction

  // Issue one operation and wait for out_valid; lat counts falling edges from the accept edge.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input logic rdy, output logic [W-1:0] d, output logic bo,
                       output logic ov, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    out_ready = rdy;
    in_valid  = 1'b1;
    a         = oa;
    b         = ob;
    borrow_in = obin;
    @(negedge clk);
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    d  = diff;
    bo = borrow_out;
    ov = overflow;
  endtask

  vec_t         vecs[7];
  logic [W-1:0] gd, ed, held;
  logic         gbo, gov, ebo, eov, rdy;
  int           lat;

  initial begin
    vecs[0] = '{16'h1234, 16'h0111, 1'b0, 16'h1123, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, OV1,      1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, OV2,      1'b1, 1'b1};
    vecs[5] = '{16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset borrow_out", 32'(borrow_out), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, gd, gbo, gov, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(NIB + 1));
      check($sformatf("vec%0d diff", i), 32'(gd), 32'(vecs[i].d));
      check($sformatf("vec%0d borrow_out", i), 32'(gbo), 32'(vecs[i].bo));
      check($sformatf("vec%0d overflow", i), 32'(gov), 32'(vecs[i].ov));
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d release", i), {30'd0, out_valid, in_ready}, 32'b01);
      out_ready = 1'b0;
    end

    // Backpressure: result held for 10 cycles, a stray in_valid is ignored.
    do_op(16'h4321, 16'h1234, 1'b0, 1'b0, gd, gbo, gov, lat);
    held = diff;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3);
      a = 16'hAAAA; b = 16'h5555;
      @(negedge clk);
      check("hold diff", 32'(diff), 32'(held));
      check("hold valid/ready", {30'd0, out_valid, in_ready}, 32'b10);
    end
    in_valid  = 1'b0;
    check("hold value", 32'(held), 32'h30ED);
    out_ready = 1'b1;
    @(negedge clk);
    check("hold release", {30'd0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b0;
    repeat (NIB + 3) @(negedge clk);
    check("no phantom op", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset while processing nibble 2 abandons the operation.
    in_valid = 1'b1; a = 16'h9999; b = 16'h1111; borrow_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun reset diff", 32'(diff), 32'd0);
    for (int k = 0; k < NIB + 4; k++) begin
      @(negedge clk);
      check("midrun reset quiet", {30'd0, out_valid, in_ready}, 32'b01);
    end

    // Random operations, sometimes with out_ready held high in advance.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = (n % 5 == 0) ? ra : W'($urandom);
      rbin = 1'($urandom);
      rdy  = 1'($urandom);
      model(ra, rb, rbin, ed, ebo, eov);
      do_op(ra, rb, rbin, rdy, gd, gbo, gov, lat);
      check($sformatf("rand%0d latency", n), 32'(lat), 32'(NIB + 1));
      check($sformatf("rand%0d result a=%h b=%h bin=%0d", n, ra, rb, rbin),
            {14'd0, gbo, gov, gd}, {14'd0, ebo, eov, ed});
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("rand%0d release", n), 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
